// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared sizes, widths and types for the HUB75 frame buffer.
//               Holds panel geometry, derived index widths, the controller
//               state encoding and the pixel colour type.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

  // Panel geometry
  localparam int COLS       = 64;
  localparam int ROW_ADDRS  = 16;
  localparam int COLOR_BITS = 3;

  // Derived widths
  localparam int COL_W     = $clog2(COLS);        // 6
  localparam int ADDR_W    = $clog2(ROW_ADDRS);   // 4
  localparam int ROW_W     = ADDR_W + 1;          // 5, top bit picks the half
  localparam int RAM_AW    = ADDR_W + COL_W;      // 10
  localparam int RAM_DEPTH = COLS * ROW_ADDRS;    // 1024

  // Controller states
  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  // One pixel, {R,G,B}
  typedef logic [COLOR_BITS-1:0] rgb_t;

endpackage
`default_nettype wire

// File: rtl/hub75_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : hub75_bank_ram
// Description : Simple dual-port synchronous RAM. One write port, one read
//               port with a registered output that only updates on re.
// Ports       : clk   - clock
//               we    - write enable
//               waddr - write address
//               wdata - write data
//               re    - read enable
//               raddr - read address
//               rdata - registered read data (holds when re=0)
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_bank_ram #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 3,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/hub75_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : hub75_frame_buffer
// Description : Double-buffered pixel store feeding a HUB75 row scanner.
//               The writer fills the back bank; a requested swap is applied
//               only when the scanner signals a frame boundary.
// Ports       : CLOCK, RESET          - clock, synchronous active-high reset
//               wr_en/wr_x/wr_y/wr_rgb - single-pixel write into back bank
//               wr_ready               - back bank accepts writes
//               wr_frame_done          - request swap
//               swap_pending           - swap requested, not yet done
//               wr_drop                - sticky: write seen while not ready
//               frame_start            - scanner wrapped to address 0
//               rd_en/rd_addr/rd_col   - read request (front bank)
//               rd_valid/rgb1/rgb2     - read response, 1-cycle latency
//               front_sel              - bank currently displayed
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_frame_buffer
  import hub75_pkg::*;
(
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_x,
  input  logic [ROW_W-1:0]  wr_y,
  input  logic [2:0]        wr_rgb,
  output logic              wr_ready,
  input  logic              wr_frame_done,
  output logic              swap_pending,
  output logic              wr_drop,
  input  logic              frame_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [COL_W-1:0]  rd_col,
  output logic              rd_valid,
  output logic [2:0]        rgb1,
  output logic [2:0]        rgb2,
  output logic              front_sel
);

  localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(RAM_DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [RAM_AW-1:0] clr_cnt;
  logic              do_swap;
  logic              in_init;

  // Read-side registers: bank select and INIT blanking captured with the
  // request so the response matches the bank that was front at issue time.
  logic              rd_sel;
  logic              rd_zero;

  logic [RAM_AW-1:0] ram_waddr;
  rgb_t              ram_wdata;
  logic [RAM_AW-1:0] ram_raddr;
  rgb_t              ram_q [2][2];   // [bank][half]

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_ready     = 1'b0;
    swap_pending = 1'b0;
    do_swap      = 1'b0;
    in_init      = 1'b0;
    case (state)
      INIT: begin
        in_init = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        wr_ready = 1'b1;
        // A simultaneous frame_start is deliberately not honoured here:
        // the swap must wait for the following frame boundary.
        if (wr_frame_done) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        swap_pending = 1'b1;
        if (frame_start) begin
          do_swap   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Clear counter, bank select, sticky drop flag
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      clr_cnt   <= '0;
      front_sel <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      if (in_init) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (do_swap) begin
        front_sel <= ~front_sel;
      end
      if (wr_en && !wr_ready) begin
        wr_drop <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bank RAMs: bank{0,1} x half{top,bottom}
  // --------------------------------------------------------------------------
  assign ram_waddr = in_init ? clr_cnt : {wr_y[ADDR_W-1:0], wr_x};
  assign ram_wdata = in_init ? rgb_t'(0) : wr_rgb;
  assign ram_raddr = {rd_addr, rd_col};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic we;
      // INIT clears every RAM in parallel; in RUN only the back bank and
      // the half chosen by the row MSB take the write.
      assign we = in_init ||
                  (wr_ready && wr_en &&
                   (front_sel == ~1'(b)) && (wr_y[ROW_W-1] == 1'(h)));

      hub75_bank_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (COLOR_BITS)
      ) u_ram (
        .clk   (CLOCK),
        .we    (we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_en),
        .raddr (ram_raddr),
        .rdata (ram_q[b][h])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Read response
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_valid <= 1'b0;
      rd_sel   <= 1'b0;
      rd_zero  <= 1'b1;   // outputs read as 000 until a real read lands
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel  <= front_sel;
        rd_zero <= in_init;
      end
    end
  end

  assign rgb1 = rd_zero ? 3'b000 : ram_q[rd_sel][0];
  assign rgb2 = rd_zero ? 3'b000 : ram_q[rd_sel][1];

endmodule
`default_nettype wire

// File: tb/tb_hub75_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_frame_buffer
// Description : Directed self-checking bench for hub75_frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_frame_buffer;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [2:0] wr_rgb = '0;
  logic       wr_ready;
  logic       wr_frame_done = 1'b0;
  logic       swap_pending;
  logic       wr_drop;
  logic       frame_start = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [5:0] rd_col = '0;
  logic       rd_valid;
  logic [2:0] rgb1;
  logic [2:0] rgb2;
  logic       front_sel;

  int checks   = 0;
  int failures = 0;

  hub75_frame_buffer dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_rgb        (wr_rgb),
    .wr_ready      (wr_ready),
    .wr_frame_done (wr_frame_done),
    .swap_pending  (swap_pending),
    .wr_drop       (wr_drop),
    .frame_start   (frame_start),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_col        (rd_col),
    .rd_valid      (rd_valid),
    .rgb1          (rgb1),
    .rgb2          (rgb2),
    .front_sel     (front_sel)
  );

  always #5 CLOCK = ~CLOCK;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic write_px(input logic [5:0] x, input logic [4:0] y, input logic [2:0] c);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_px(input logic [3:0] a, input logic [5:0] c);
    rd_en = 1'b1; rd_addr = a; rd_col = c;
    step();
    rd_en = 1'b0;
  endtask

  task automatic pulse_done();
    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  // Counts cycles with wr_ready low, bounded.
  task automatic count_init(output int n);
    n = 0;
    while (wr_ready !== 1'b1 && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++;
    if ({front_sel, swap_pending, wr_ready, wr_drop, rd_valid, rgb1, rgb2} !== 11'b0) begin
      failures++;
      $display("FAIL reset_values got fs=%b sp=%b rdy=%b drop=%b v=%b rgb1=%b rgb2=%b want all 0",
               front_sel, swap_pending, wr_ready, wr_drop, rd_valid, rgb1, rgb2);
    end
    count_init(n);
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL init_length got %0d want 1024", n);
    end
    read_px(4'd5, 6'd10);
    checks++;
    if (rd_valid !== 1'b1 || rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
      failures++;
      $display("FAIL cleared_read got v=%b rgb1=%b rgb2=%b want 1 000 000", rd_valid, rgb1, rgb2);
    end
  endtask

  task automatic test_write_swap_read();
    write_px(6'd3, 5'd2, 3'b110);
    write_px(6'd3, 5'd18, 3'b011);
    pulse_done();
    pulse_fs();
    read_px(4'd2, 6'd3);
    checks++;
    if (rd_valid !== 1'b1 || rgb1 !== 3'b110 || rgb2 !== 3'b011 || front_sel !== 1'b1) begin
      failures++;
      $display("FAIL swap_read got v=%b rgb1=%b rgb2=%b fs=%b want 1 110 011 1",
               rd_valid, rgb1, rgb2, front_sel);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || rgb1 !== 3'b110 || rgb2 !== 3'b011) begin
      failures++;
      $display("FAIL read_hold got v=%b rgb1=%b rgb2=%b want 0 110 011", rd_valid, rgb1, rgb2);
    end
  endtask

  task automatic test_double_buffer();
    write_px(6'd63, 5'd31, 3'b111);
    pulse_done();
    pulse_fs();
    read_px(4'd15, 6'd63);
    checks++;
    if (rgb2 !== 3'b111 || rgb1 !== 3'b000 || front_sel !== 1'b0) begin
      failures++;
      $display("FAIL dbuf_new got rgb1=%b rgb2=%b fs=%b want 000 111 0", rgb1, rgb2, front_sel);
    end
    read_px(4'd2, 6'd3);
    checks++;
    if (rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
      failures++;
      $display("FAIL dbuf_old_hidden got rgb1=%b rgb2=%b want 000 000", rgb1, rgb2);
    end
  endtask

  task automatic test_no_tearing();
    write_px(6'd0, 5'd0, 3'b101);
    pulse_done();
    read_px(4'd0, 6'd0);
    checks++;
    if (rgb1 !== 3'b000 || swap_pending !== 1'b1 || wr_ready !== 1'b0 || wr_drop !== 1'b0) begin
      failures++;
      $display("FAIL no_tear got rgb1=%b sp=%b rdy=%b drop=%b want 000 1 0 0",
               rgb1, swap_pending, wr_ready, wr_drop);
    end
    write_px(6'd1, 5'd0, 3'b111);   // dropped
    checks++;
    if (wr_drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_set got %b want 1", wr_drop);
    end
    pulse_fs();
    read_px(4'd0, 6'd0);
    checks++;
    if (rgb1 !== 3'b101 || front_sel !== 1'b1 || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL late_swap got rgb1=%b fs=%b sp=%b want 101 1 0", rgb1, front_sel, swap_pending);
    end
    read_px(4'd0, 6'd1);
    checks++;
    if (rgb1 !== 3'b000) begin
      failures++;
      $display("FAIL dropped_write got %b want 000", rgb1);
    end
  endtask

  task automatic test_simultaneous();
    wr_frame_done = 1'b1;
    frame_start   = 1'b1;
    step();
    wr_frame_done = 1'b0;
    frame_start   = 1'b0;
    checks++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL simultaneous got fs=%b sp=%b want 1 1", front_sel, swap_pending);
    end
    pulse_done();   // repeated request while pending
    checks++;
    if (front_sel !== 1'b1 || swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL repeat_done got fs=%b sp=%b want 1 1", front_sel, swap_pending);
    end
    pulse_fs();
    checks++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0 || wr_ready !== 1'b1 || wr_drop !== 1'b1) begin
      failures++;
      $display("FAIL next_fs_swap got fs=%b sp=%b rdy=%b drop=%b want 0 0 1 1",
               front_sel, swap_pending, wr_ready, wr_drop);
    end
  endtask

  task automatic test_reset_mid_pending();
    int n;
    write_px(6'd3, 5'd2, 3'b010);   // bank 1 top
    pulse_done();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++;
    if (swap_pending !== 1'b0 || front_sel !== 1'b0 || wr_drop !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got sp=%b fs=%b drop=%b rdy=%b want 0 0 0 0",
               swap_pending, front_sel, wr_drop, wr_ready);
    end
    read_px(4'd15, 6'd63);          // issued during INIT
    checks++;
    if (rd_valid !== 1'b1 || rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
      failures++;
      $display("FAIL init_read got v=%b rgb1=%b rgb2=%b want 1 000 000", rd_valid, rgb1, rgb2);
    end
    count_init(n);
    checks++;
    if (n != 1023) begin
      failures++;
      $display("FAIL reinit_length got %0d want 1023 after one read cycle", n);
    end
    read_px(4'd15, 6'd63);
    checks++;
    if (rgb2 !== 3'b000) begin
      failures++;
      $display("FAIL recleared_bank0 got %b want 000", rgb2);
    end
    pulse_done();
    pulse_fs();
    read_px(4'd0, 6'd0);
    checks++;
    if (rgb1 !== 3'b000 || front_sel !== 1'b1) begin
      failures++;
      $display("FAIL recleared_bank1 got rgb1=%b fs=%b want 000 1", rgb1, front_sel);
    end
    read_px(4'd2, 6'd3);
    checks++;
    if (rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
      failures++;
      $display("FAIL recleared_pair got rgb1=%b rgb2=%b want 000 000", rgb1, rgb2);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_write_swap_read();
    test_double_buffer();
    test_no_tearing();
    test_simultaneous();
    test_reset_mid_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
